tick_sample_reader: RTL and testbench

//  Consumer end of the game clock tick interface. Watches counter_out/counter_update/write_100m

---
 rtl/tick_sample_reader_pkg.sv | 15 +
 rtl/tick_sample_reader_if.sv | 11 +
 rtl/tick_sample_reader_fifo.sv | 48 ++++
 rtl/tick_sample_reader.sv | 86 ++++++++
 tb/tb_tick_sample_reader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/tick_sample_reader_pkg.sv
// Shared widths and entry layout for the game-clock tick sample reader.
// An entry is packed as {gap, timestamp, data}, MSB first.
package tick_sample_reader_pkg;
    localparam int TS_W    = 10;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = 1 + TS_W + DATA_W;
    localparam int TS_LSB  = DATA_W;
    localparam int GAP_BIT = ENTRY_W - 1;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic gap,
                                                     input logic [TS_W-1:0] ts,
                                                     input logic [DATA_W-1:0] data);
        return {gap, ts, data};
    endfunction
endpackage

// File: rtl/tick_sample_reader_if.sv
// Reader-side valid/ready handshake carrying one captured entry.
interface tick_sample_reader_if;
    import tick_sample_reader_pkg::*;

    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/tick_sample_reader_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// Head word reads as zero while empty so the output is clean out of reset.
module tick_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign pop_ok  = pop && !empty;
    // A full FIFO can still accept when the head leaves on the same edge.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/tick_sample_reader.sv
// Captures {gap, timestamp, sample} on each write_100m strobe into a FIFO for a
// downstream reader, flagging timeline discontinuities and dropped strobes.
module tick_sample_reader
    import tick_sample_reader_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic                    CLOCK50M,
    input  logic                    KEY0,
    input  logic [TS_W-1:0]         counter_out,
    input  logic                    counter_update,
    input  logic                    write_100m,
    input  logic [DATA_W-1:0]       sample_data,
    tick_sample_reader_if.master    rd,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_count,
    input  logic                    clear_status
);
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              gap_pending;
    logic              have_prev;
    logic [TS_W-1:0]   prev_ts;
    logic [TS_W-1:0]   ts_expect;
    logic              gap_now;
    logic              gap_next;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push_ok;
    logic              drop;

    // Expected successor wraps naturally, so max -> 0 is continuous.
    assign ts_expect = prev_ts + 1'b1;
    assign gap_now   = counter_update && have_prev && (counter_out != ts_expect);
    assign gap_next  = gap_pending || gap_now;

    assign pop       = !empty && rd.rd_ready;
    assign push_ok   = write_100m && (!full || pop);
    assign drop      = write_100m && full && !pop;
    assign rd.rd_valid = !empty;

    tick_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLOCK50M),
        .rst_n (KEY0),
        .push  (write_100m),
        .pop   (pop),
        .din   (pack_entry(gap_next, counter_out, sample_data)),
        .dout  (rd.rd_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge CLOCK50M or negedge KEY0) begin
        if (!KEY0) begin
            gap_pending <= 1'b0;
            have_prev   <= 1'b0;
            prev_ts     <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (counter_update) begin
                prev_ts   <= counter_out;
                have_prev <= 1'b1;
            end
            // The gap travels with the first entry that actually lands in the FIFO.
            gap_pending <= push_ok ? 1'b0 : gap_next;

            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= clear_status ? DROP_W'(1) : sat_inc(drop_count);
            end else if (clear_status) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_tick_sample_reader.sv
// Bench for tick_sample_reader: directed tables/sequences plus randomized traffic
// against a queue-based reference model.
module tb_tick_sample_reader;
    import tick_sample_reader_pkg::*;

    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [TS_W-1:0]   counter_out = '0;
    logic              counter_update = 1'b0;
    logic              write_100m = 1'b0;
    logic [DATA_W-1:0] sample_data = '0;
    logic [4:0]        fifo_count;
    logic              overflow;
    logic [7:0]        drop_count;
    logic              clear_status = 1'b0;

    tick_sample_reader_if rd_if();

    tick_sample_reader #(.DEPTH(DEPTH), .DROP_W(8)) dut (
        .CLOCK50M       (clk),
        .KEY0           (rst_n),
        .counter_out    (counter_out),
        .counter_update (counter_update),
        .write_100m     (write_100m),
        .sample_data    (sample_data),
        .rd             (rd_if),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_status   (clear_status)
    );

    always #10 clk = ~clk;

    int vecs  = 0;
    int fails = 0;

    // Reference model state
    logic [ENTRY_W-1:0] mq[$];
    logic               m_gap;
    logic               m_have;
    int                 m_prev;
    logic               m_ov;
    int                 m_drop;

    typedef struct {
        logic              upd;
        logic [TS_W-1:0]   ts;
        logic              wr;
        logic [DATA_W-1:0] d;
        logic              rdy;
        logic              ev;
        logic [ENTRY_W-1:0] edata;
        logic [4:0]        ecnt;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_gap = 1'b0; m_have = 1'b0; m_prev = 0; m_ov = 1'b0; m_drop = 0;
    endtask

    task automatic do_reset();
        counter_update = 0; write_100m = 0; rd_if.rd_ready = 0; clear_status = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", rd_if.rd_valid, 0);
        chk("rst_count", fifo_count, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Apply one cycle of inputs, advance the model by the same event, compare.
    task automatic cycle(input logic upd, input int ts, input logic wr,
                         input logic [DATA_W-1:0] d, input logic rdy, input logic clr,
                         input string tag);
        logic gapn;
        logic pop;
        logic full;
        counter_update = upd; counter_out = TS_W'(ts); write_100m = wr;
        sample_data = d; rd_if.rd_ready = rdy; clear_status = clr;

        pop  = (mq.size() > 0) && rdy;
        full = (mq.size() == DEPTH);
        gapn = m_gap || (upd && m_have && (ts != ((m_prev + 1) % (1 << TS_W))));
        if (upd) begin m_prev = ts; m_have = 1'b1; end
        if (pop) void'(mq.pop_front());
        if (wr && (!full || pop)) begin
            mq.push_back({gapn, TS_W'(ts), d});
            m_gap = 1'b0;
        end else begin
            m_gap = gapn;
        end
        if (wr && full && !pop) begin
            m_ov = 1'b1;
            m_drop = clr ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
        end else if (clr) begin
            m_ov = 1'b0; m_drop = 0;
        end

        @(posedge clk); #1;
        chk({tag, "_valid"}, rd_if.rd_valid, mq.size() > 0);
        chk({tag, "_data"},  rd_if.rd_data, mq.size() > 0 ? mq[0] : '0);
        chk({tag, "_count"}, fifo_count, mq.size());
        chk({tag, "_ovf"},   overflow, m_ov);
        chk({tag, "_drop"},  drop_count, m_drop);
    endtask

    initial begin
        int ts_r;
        model_reset();
        #25;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("init_valid", rd_if.rd_valid, 0);
        chk("init_data", rd_if.rd_data, 0);

        // Reset mid-run with three entries queued
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'(i + 1), 0, 0, "t1");
        chk("t1_pre_count", fifo_count, 3);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_async_valid", rd_if.rd_valid, 0);
        chk("t1_async_count", fifo_count, 0);
        chk("t1_async_ovf", overflow, 0);
        chk("t1_async_data", rd_if.rd_data, 0);
        do_reset();

        // Single capture, held until accepted
        tv[0] = '{1, 10'd1, 0, 8'h00, 0, 0, 19'h0, 5'd0};
        tv[1] = '{1, 10'd2, 0, 8'h00, 0, 0, 19'h0, 5'd0};
        tv[2] = '{1, 10'd3, 1, 8'hA5, 0, 1, 19'h003A5, 5'd1};
        tv[3] = '{1, 10'd4, 0, 8'h00, 0, 1, 19'h003A5, 5'd1};
        tv[4] = '{1, 10'd5, 0, 8'h00, 0, 1, 19'h003A5, 5'd1};
        tv[5] = '{0, 10'd5, 0, 8'h00, 1, 0, 19'h0, 5'd0};
        for (int i = 0; i < 6; i++) begin
            cycle(tv[i].upd, tv[i].ts, tv[i].wr, tv[i].d, tv[i].rdy, 0, "t2");
            chk($sformatf("t2_tab_valid%0d", i), rd_if.rd_valid, tv[i].ev);
            chk($sformatf("t2_tab_data%0d", i), rd_if.rd_data, tv[i].edata);
            chk($sformatf("t2_tab_count%0d", i), fifo_count, tv[i].ecnt);
        end

        // Counter wrap is continuous
        do_reset();
        cycle(1, 1022, 1, 8'h11, 0, 0, "t3");
        cycle(1, 1023, 1, 8'h22, 0, 0, "t3");
        cycle(1, 0,    1, 8'h33, 0, 0, "t3");
        cycle(1, 1,    1, 8'h44, 0, 0, "t3");
        chk("t3_count", fifo_count, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_gap%0d", i), rd_if.rd_data[GAP_BIT], 0);
            cycle(0, 1, 0, 8'h00, 1, 0, "t3");
        end

        // Clock cleared: the same-cycle strobe carries the gap, the next does not
        do_reset();
        cycle(1, 7, 0, 8'h00, 0, 0, "t4");
        cycle(1, 1, 1, 8'h5A, 0, 0, "t4");
        chk("t4_gap_entry", rd_if.rd_data, {1'b1, 10'd1, 8'h5A});
        cycle(0, 1, 1, 8'h6B, 1, 0, "t4");
        chk("t4_next_entry", rd_if.rd_data, {1'b0, 10'd1, 8'h6B});

        // Overflow and full-with-pop
        do_reset();
        for (int i = 0; i < 17; i++) cycle(0, 0, 1, 8'(i), 0, 0, "t5");
        chk("t5_count", fifo_count, 16);
        chk("t5_ovf", overflow, 1);
        chk("t5_drop", drop_count, 1);
        cycle(0, 0, 1, 8'hEE, 1, 0, "t5f");
        chk("t5f_count", fifo_count, 16);
        chk("t5f_drop", drop_count, 1);

        // Drop counter saturation and status clear
        for (int i = 0; i < 254; i++) cycle(0, 0, 1, 8'h00, 0, 0, "t6");
        chk("t6_ff", drop_count, 8'hFF);
        cycle(0, 0, 1, 8'h00, 0, 0, "t6s");
        chk("t6_sat", drop_count, 8'hFF);
        cycle(0, 0, 1, 8'h00, 0, 1, "t6w");
        chk("t6_clr_drop_wins", drop_count, 1);
        chk("t6_clr_drop_ovf", overflow, 1);
        cycle(0, 0, 0, 8'h00, 0, 1, "t6c");
        chk("t6_clr_count", drop_count, 0);
        chk("t6_clr_ovf", overflow, 0);

        // Randomized traffic
        do_reset();
        ts_r = 0;
        for (int i = 0; i < 3000; i++) begin
            logic upd, wr, rdy, clr;
            upd = $urandom_range(0, 1);
            if (upd) ts_r = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : (ts_r + 1) % 1024;
            wr  = $urandom_range(0, 1);
            rdy = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            cycle(upd, ts_r, wr, 8'($urandom), rdy, clr, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
